// File: rtl/trig_pkg.sv
// Shared types, widths and the quadrant fold helper for trig_lut_sched.
// No ports: imported by trig_lut_sched and rr_arbiter.
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } sched_state_t;

    localparam int ANGLE_W = 10;
    localparam int LUT_W   = 8;
    localparam int RES_W   = 9;

    localparam logic [ANGLE_W-1:0] QUARTER = 10'd256;

    typedef struct packed {
        logic [LUT_W-1:0] idx;
        logic             neg;
    } fold_t;

    // Odd quadrants mirror the index; the lower half-circle is negative.
    function automatic fold_t fold_angle(input logic [ANGLE_W-1:0] e);
        fold_t f;
        f.idx = e[8] ? ~e[7:0] : e[7:0];
        f.neg = e[9];
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
// Ports: valid[N], ptr[IDW] in; grant[N] one-hot, id[IDW], any out.
module rr_arbiter
    import trig_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id,
    output logic           any
);

    localparam logic [IDW:0] NV = (IDW+1)'(N);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDW:0] pos;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= NV) begin
                pos = pos - NV;
            end
            if (!any && valid[pos[IDW-1:0]]) begin
                any                   = 1'b1;
                grant[pos[IDW-1:0]]   = 1'b1;
                id                    = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/trig_lut_sched.sv
// Round-robin scheduler sharing one sine table among NREQ sin/cos requesters.
// Ports: clk, rst_n; req_valid/req_cos/req_angle in, req_ready out (one-hot);
//   lut_a out / lut_s in (external table); rsp_valid, rsp_id, rsp_value out,
//   rsp_ready in. Define TRIG_LUT_SCHED_CNT_EN to add lookup_count[15:0],
//   a saturating count of completed responses.
module trig_lut_sched
    import trig_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_cos,
    input  logic [NREQ*ANGLE_W-1:0] req_angle,
    output logic [NREQ-1:0]         req_ready,
    output logic [LUT_W-1:0]        lut_a,
    input  logic [LUT_W-1:0]        lut_s,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [RES_W-1:0]        rsp_value
`ifdef TRIG_LUT_SCHED_CNT_EN
    ,
    output logic [15:0]             lookup_count
`endif
);

    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             neg_q, neg_d;
    logic [LUT_W-1:0] lut_a_q, lut_a_d;
    logic [RES_W-1:0] rsp_value_q, rsp_value_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;
    logic [ANGLE_W-1:0] sel_angle;
    logic               sel_cos;
    logic [ANGLE_W-1:0] eff_angle;
    fold_t              fold;
    logic               idle;
    logic               accept;
    logic               rsp_fire;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_gnt),
        .id    (arb_id),
        .any   (arb_any)
    );

    always_comb begin
        sel_angle = '0;
        sel_cos   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
                sel_cos   = req_cos[i];
            end
        end
    end

    // Cosine is sine a quarter turn ahead; the add wraps at 10 bits.
    assign eff_angle = sel_angle + (sel_cos ? QUARTER : {ANGLE_W{1'b0}});
    assign fold      = fold_angle(eff_angle);

    assign idle     = (state_q == IDLE);
    assign accept   = idle && arb_any;
    assign rsp_fire = (state_q == RESP) && rsp_ready;

    // Gated by rst_n so no grant is visible while reset is held.
    assign req_ready = (idle && rst_n) ? arb_gnt : '0;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        neg_d       = neg_q;
        lut_a_d     = lut_a_q;
        rsp_value_d = rsp_value_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = arb_id;
                    lut_a_d = fold.idx;
                    neg_d   = fold.neg;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                rsp_value_d = neg_q ? ({RES_W{1'b0}} - {1'b0, lut_s})
                                    : {1'b0, lut_s};
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == LAST) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            neg_q       <= 1'b0;
            lut_a_q     <= '0;
            rsp_value_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            neg_q       <= neg_d;
            lut_a_q     <= lut_a_d;
            rsp_value_q <= rsp_value_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign lut_a     = lut_a_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_value = rsp_value_q;

`ifdef TRIG_LUT_SCHED_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_fire && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lookup_count = cnt_q;
`else
    logic unused_fire;
    assign unused_fire = rsp_fire;
`endif

endmodule
